// File: rtl/control_multicycle_if.sv
// control_multicycle_if: instruction/flag inputs and control strobes between the FSM and the datapath.
interface control_multicycle_if;
    logic [31:0] instr;
    logic        zero;
    logic        ir_ld_en;
    logic        pc_ld_en;
    logic        pc_sel;
    logic        rf_b_sel;
    logic [1:0]  imm_ext;
    logic        alu_bin_sel;
    logic [3:0]  alu_func;
    logic        mem_wr_en;
    logic        byte_op;
    logic        rf_wr_en;
    logic        rf_wr_data_sel;
    logic [2:0]  state;
    modport master (
        input  instr, zero,
        output ir_ld_en, pc_ld_en, pc_sel, rf_b_sel, imm_ext, alu_bin_sel,
               alu_func, mem_wr_en, byte_op, rf_wr_en, rf_wr_data_sel, state
    );
    modport slave (
        output instr, zero,
        input  ir_ld_en, pc_ld_en, pc_sel, rf_b_sel, imm_ext, alu_bin_sel,
               alu_func, mem_wr_en, byte_op, rf_wr_en, rf_wr_data_sel, state
    );
endinterface

// File: rtl/control_multicycle.sv
// control_multicycle: multicycle IF/DEC/EX/MEM/WB sequencer decoding control for a MIPS-style datapath.
module control_multicycle (
    input logic clk,
    input logic rst,
    control_multicycle_if.master bus
);
    typedef enum logic [2:0] {S_IF = 3'd0, S_DEC = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
    state_t state, next;
    logic [5:0] op;
    logic r_type, add_imm, lui, andi, ori, is_b, is_beq, is_bne, is_br, ld, st, supported, taken, dec;
    assign op        = bus.instr[31:26];
    assign r_type    = op == 6'b100000;
    assign lui       = op == 6'b111001;
    assign add_imm   = op == 6'b111000 || op == 6'b110000 || lui;
    assign andi      = op == 6'b110010;
    assign ori       = op == 6'b110011;
    assign is_b      = op == 6'b111111;
    assign is_beq    = op == 6'b000000;
    assign is_bne    = op == 6'b000001;
    assign is_br     = is_b || is_beq || is_bne;
    assign ld        = op == 6'b000011 || op == 6'b001111;
    assign st        = op == 6'b000111 || op == 6'b011111;
    assign supported = r_type || add_imm || andi || ori || is_br || ld || st;
    assign taken     = is_b || (is_beq && bus.zero) || (is_bne && !bus.zero);
    assign dec       = state != S_IF;
    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= next;
    end
    always_comb begin
        next = S_IF;
        case (state)
            S_IF:    next = S_DEC;
            S_DEC:   next = supported ? S_EX : S_IF;
            S_EX:    next = (ld || st) ? S_MEM : is_br ? S_IF : S_WB;
            S_MEM:   next = ld ? S_WB : S_IF;
            default: next = S_IF;
        endcase
        bus.state          = state;
        bus.alu_func       = !dec ? 4'd0 : r_type ? bus.instr[3:0] : andi ? 4'd2 : ori ? 4'd3 : is_br ? 4'd1 : 4'd0;
        bus.imm_ext        = !dec ? 2'd0 : is_br ? 2'd3 : (andi || ori) ? 2'd1 : lui ? 2'd2 : 2'd0;
        bus.alu_bin_sel    = dec && (add_imm || andi || ori || ld || st);
        bus.rf_b_sel       = dec && (is_br || st);
        bus.byte_op        = dec && (op == 6'b000011 || op == 6'b000111);
        bus.rf_wr_data_sel = dec && ld;
        // strobes are masked by reset so an aborted instruction never writes
        bus.ir_ld_en       = !rst && state == S_IF;
        bus.rf_wr_en       = !rst && state == S_WB;
        bus.mem_wr_en      = !rst && state == S_MEM && st;
        bus.pc_ld_en       = !rst && (state == S_WB || (state == S_MEM && st) ||
                             (state == S_EX && is_br) || (state == S_DEC && !supported));
        bus.pc_sel         = !rst && state == S_EX && is_br && taken;
    end
endmodule

// File: tb/tb_control_multicycle.sv
// tb_control_multicycle: randomized and directed checks of control_multicycle against a cycle-table model.
module tb_control_multicycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    control_multicycle_if bus ();
    control_multicycle dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [5:0] OPS [12] = '{6'b100000, 6'b111000, 6'b110000, 6'b111001, 6'b110010, 6'b110011,
                                        6'b111111, 6'b000000, 6'b000001, 6'b000011, 6'b001111, 6'b000111};

    function automatic logic [17:0] got();
        return {bus.state, bus.ir_ld_en, bus.pc_ld_en, bus.pc_sel, bus.rf_b_sel, bus.imm_ext, bus.alu_bin_sel,
                bus.alu_func, bus.mem_wr_en, bus.byte_op, bus.rf_wr_en, bus.rf_wr_data_sel};
    endfunction

    function automatic int lat(logic [31:0] i);
        logic [5:0] o;
        o = i[31:26];
        if (o == 6'b000011 || o == 6'b001111) return 5;
        if (o == 6'b000111 || o == 6'b011111) return 4;
        if (o == 6'b111111 || o == 6'b000000 || o == 6'b000001) return 3;
        if (o inside {6'b100000, 6'b111000, 6'b110000, 6'b111001, 6'b110010, 6'b110011}) return 4;
        return 2;
    endfunction

    // expected outputs in cycle c (1 = IF) of instruction i
    function automatic logic [17:0] model(logic [31:0] i, logic z, int c);
        logic [5:0] o;
        logic rt, li_add, lui, andi, ori, br, ld, st, alu, byt, tk, d, last;
        logic [2:0] s;
        logic [3:0] f;
        logic [1:0] ie;
        int l;
        o = i[31:26];
        rt = o == 6'b100000;
        li_add = o == 6'b111000 || o == 6'b110000;
        lui = o == 6'b111001;
        andi = o == 6'b110010;
        ori = o == 6'b110011;
        br = o == 6'b111111 || o == 6'b000000 || o == 6'b000001;
        ld = o == 6'b000011 || o == 6'b001111;
        st = o == 6'b000111 || o == 6'b011111;
        byt = o == 6'b000011 || o == 6'b000111;
        alu = rt || li_add || lui || andi || ori;
        tk = o == 6'b111111 || (o == 6'b000000 && z) || (o == 6'b000001 && !z);
        l = lat(i);
        d = c > 1;
        last = c == l;
        s = c == 1 ? 3'd0 : c == 2 ? 3'd1 : c == 3 ? 3'd2 : (c == 4 && (ld || st)) ? 3'd3 : 3'd4;
        f = !d ? 4'd0 : rt ? i[3:0] : andi ? 4'd2 : ori ? 4'd3 : br ? 4'd1 : 4'd0;
        ie = !d ? 2'd0 : br ? 2'd3 : (andi || ori) ? 2'd1 : lui ? 2'd2 : 2'd0;
        return {s, c == 1, last, last && br && tk, d && (br || st), ie,
                d && (li_add || lui || andi || ori || ld || st), f,
                last && st, d && byt, last && (alu || ld), d && ld};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.instr = 32'h0;
        bus.zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.state, bus.ir_ld_en, bus.pc_ld_en, bus.rf_wr_en, bus.mem_wr_en} !== 7'd0) begin
                errors++;
                $display("FAIL reset_hold k=%0d state=%0d ir=%b pc=%b rf=%b mem=%b want all 0", k, bus.state,
                         bus.ir_ld_en, bus.pc_ld_en, bus.rf_wr_en, bus.mem_wr_en);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ir_ld_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ir_ld_en=%b want 1", bus.ir_ld_en);
        end
    endtask

    task automatic test_rtype();
        logic [31:0] i;
        logic [17:0] e;
        i = 32'h8000_0030;
        for (int c = 1; c <= lat(i); c++) begin
            bus.instr = i; bus.zero = 1'b0; #1;
            e = model(i, 1'b0, c);
            checks++;
            if (got() !== e) begin
                errors++;
                $display("FAIL rtype_add c=%0d got=%h want=%h", c, got(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_store();
        logic [31:0] prog [4] = '{32'h3C22_0008, 32'h7C22_0008, 32'h0C43_FFFC, 32'h1C43_0001};
        logic [17:0] e;
        foreach (prog[n])
            for (int c = 1; c <= lat(prog[n]); c++) begin
                bus.instr = prog[n]; bus.zero = 1'b1; #1;
                e = model(prog[n], 1'b1, c);
                checks++;
                if (got() !== e) begin
                    errors++;
                    $display("FAIL load_store instr=%h c=%0d got=%h want=%h", prog[n], c, got(), e);
                end
                @(posedge clk); #1;
            end
    endtask

    task automatic test_branch();
        logic [31:0] prog [5] = '{32'h0000_0010, 32'h0000_0010, 32'h0400_0004, 32'h0400_0004, 32'hFC00_0001};
        logic zs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [17:0] e;
        foreach (prog[n])
            for (int c = 1; c <= lat(prog[n]); c++) begin
                bus.instr = prog[n]; bus.zero = zs[n]; #1;
                e = model(prog[n], zs[n], c);
                checks++;
                if (got() !== e) begin
                    errors++;
                    $display("FAIL branch instr=%h zero=%b c=%0d got=%h want=%h", prog[n], zs[n], c, got(), e);
                end
                @(posedge clk); #1;
            end
    endtask

    task automatic test_unsupported();
        logic [31:0] i;
        logic [17:0] e;
        i = 32'h5400_1234;
        for (int c = 1; c <= 3; c++) begin
            bus.instr = c == 3 ? 32'h8000_0030 : i; bus.zero = 1'b0; #1;
            e = c == 3 ? model(32'h8000_0030, 1'b0, 1) : model(i, 1'b0, c);
            checks++;
            if (got() !== e) begin
                errors++;
                $display("FAIL unsupported c=%0d got=%h want=%h", c, got(), e);
            end
            if (c < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] i;
        logic [17:0] e;
        i = 32'h3C22_0008;
        for (int c = 1; c <= 4; c++) begin
            bus.instr = i; bus.zero = 1'b0;
            if (c == 4) rst = 1'b1;
            #1;
            e = model(i, 1'b0, c);
            checks++;
            if (c < 4 && got() !== e) begin
                errors++;
                $display("FAIL reset_mid c=%0d got=%h want=%h", c, got(), e);
            end else if (c == 4 && {bus.ir_ld_en, bus.pc_ld_en, bus.rf_wr_en, bus.mem_wr_en} !== 4'd0) begin
                errors++;
                $display("FAIL reset_mid_strobes got=%b want 0000",
                         {bus.ir_ld_en, bus.pc_ld_en, bus.rf_wr_en, bus.mem_wr_en});
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        i = 32'hC022_0005;
        for (int c = 1; c <= lat(i); c++) begin
            bus.instr = i; #1;
            e = model(i, 1'b0, c);
            checks++;
            if (got() !== e) begin
                errors++;
                $display("FAIL reset_mid_resume c=%0d got=%h want=%h", c, got(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] i;
        logic [17:0] e;
        logic z;
        for (int n = 0; n < 60; n++) begin
            i = $urandom;
            if ($urandom_range(0, 4) != 0) i[31:26] = OPS[$urandom_range(0, 11)];
            if ($urandom_range(0, 5) == 0) i[31:26] = 6'b011111;
            for (int c = 1; c <= lat(i); c++) begin
                z = 1'($urandom);
                bus.instr = i; bus.zero = z; #1;
                e = model(i, z, c);
                checks++;
                if (got() !== e) begin
                    errors++;
                    $display("FAIL random instr=%h zero=%b c=%0d got=%h want=%h", i, z, c, got(), e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch();
        test_unsupported();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
